seg7_reader: RTL and testbench
==============================

Name: seg7_reader

Overview:
- Reads back a 7-segment drive bus with the same segment ordering as our seg7 decoder: bit0 = seg1 (top), bit1 = seg2 (upper right), bit2 = seg3 (lower right), bit3 = seg4 (bottom), bit4 = seg5 (lower left), bit5 = seg6 (upper left), bit6 = seg7 (middle).
- Synchronises the bus, debounces it, and converts each stable glyph to a symbol code.
- Tracks progress through the banner message "UABC-ELECTRONICA" and counts complete receptions.
- Used as a loopback checker for the scrolling display and as an input decoder for external displays.

Parameters:
- STABLE_CYCLES, 4, consecutive equal synchronised samples needed to accept a glyph (range 1..255).
- SYNC_STAGES, 2, input synchroniser depth (range 2..3).
- COUNT_W, 8, width of msg_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- segments  in  7  segment bus, asynchronous to clk, 1 = segment lit.
- char_code  out  4  last accepted symbol code.
- char_valid  out  1  one-cycle pulse when a new glyph is accepted.
- char_unknown  out  1  one-cycle pulse, coincident with char_valid, when the glyph is not in the table.
- msg_pos  out  5  number of message symbols matched so far (0..15).
- msg_done  out  1  one-cycle pulse when all 16 symbols have been matched.
- msg_count  out  COUNT_W  completed messages, saturating.

Behaviour:
- Decided: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values: all outputs 0; synchroniser contents 0; run counter 0; last accepted pattern 0x00.
- Glyph table (pattern -> code):
  - 0x00 blank -> 0, 0x3E U -> 1, 0x77 A -> 2, 0x7C B -> 3, 0x39 C -> 4, 0x40 - -> 5, 0x79 E -> 6, 0x38 L -> 7.
  - 0x31 T -> 8, 0x50 R -> 9, 0x3F O -> 10, 0x54 N -> 11, 0x30 I -> 12.
  - Any other pattern -> 15 (unknown). Codes 13 and 14 are unused.
- Debounce:
  - The run counter increments (saturating) while the synchronised sample equals the previous synchronised sample, and resets to 1 when it differs.
  - A glyph is accepted when the run counter reaches STABLE_CYCLES and the pattern differs from the last accepted pattern.
  - On acceptance: char_code is registered, char_valid pulses, and the pattern is stored as last accepted.
  - A pattern held indefinitely produces exactly one pulse.
- Latency: char_valid is high in the cycle after the (SYNC_STAGES+STABLE_CYCLES)-th rising edge that samples a new, steady pattern. With defaults this is 6 edges.
- Glitch rejection: a disturbance shorter than STABLE_CYCLES produces no pulse, including when the bus returns to the prior glyph.
- Blank: accepted like any other glyph (code 0, char_valid pulses), so repeated letters separated by blanks are each reported. The matcher ignores blanks: msg_pos is unchanged.
- Matcher, expected sequence of codes: 1,2,3,4,5,6,7,6,4,8,9,10,11,12,4,2. It updates one cycle after char_valid.
  - Non-blank code equals expected[msg_pos]: msg_pos increments. On the 16th match, msg_pos goes to 0, msg_done pulses, and msg_count increments, saturating at all ones.
  - Known code that mismatches: msg_pos goes to 1 if the code is U(1), otherwise to 0.
  - Unknown code (15): msg_pos goes to 0.
- Simultaneous events: acceptance and matcher update for consecutive glyphs can occur in back-to-back cycles (STABLE_CYCLES = 1). No pulses are lost; each is processed in order.
- Reset mid-operation: all state is cleared immediately and asynchronously. The first glyph after reset must satisfy the full latency. A steady non-blank glyph present across reset is accepted once after reset.

Optional Feature:
- Macro: SEG7_ACTIVE_LOW_EN.
- Defined: segments is inverted before the synchroniser (common-anode bus, 0 = lit). All table values above refer to the inverted, lit-high pattern. Reset value of the synchroniser becomes 0x7F raw, i.e. blank after inversion.
- Undefined: segments is used as is, lit-high.

Test Plan:
1. rst held with segments = 0x3E, then released and held -> all outputs 0 during reset. One char_valid 6 edges after release, char_code = 1, then no further pulses for 50 cycles.
2. Steady 0x3E, then 0x77 for 3 cycles, then back to 0x3E (defaults) -> no char_valid after the first, msg_pos stays 1.
3. The 16 message glyphs in order, each held 10 cycles -> 16 char_valid pulses, msg_pos steps 1..15, then msg_done single pulse, msg_pos = 0, msg_count = 1.
4. Glyph sequence U, A, C -> msg_pos 1, 2, 0. Then U, blank, U -> msg_pos 1, 1, 1 (the second U mismatches and restarts at 1).
5. segments = 0x7F steady -> char_valid and char_unknown pulse together, char_code = 15, msg_pos = 0.
6. COUNT_W = 2 with the full message sent 5 times, separated by blanks -> msg_done pulses 5 times, msg_count reaches 3 and holds at 3.

Source files
------------

// File: rtl/seg7_reader.sv
// 7-segment bus reader: synchronise, debounce, decode glyphs and track the "UABC-ELECTRONICA" banner.
// Define SEG7_ACTIVE_LOW_EN for a common-anode (0 = lit) segment bus.
module seg7_reader #(
   parameter int STABLE_CYCLES = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int COUNT_W       = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [6:0]         segments,
   output logic [3:0]         char_code,
   output logic               char_valid,
   output logic               char_unknown,
   output logic [4:0]         msg_pos,
   output logic               msg_done,
   output logic [COUNT_W-1:0] msg_count
);

`ifdef SEG7_ACTIVE_LOW_EN
   localparam logic [6:0] SYNC_RST = 7'h7F;
`else
   localparam logic [6:0] SYNC_RST = 7'h00;
`endif

   localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

   logic [SYNC_STAGES-1:0][6:0] sync_q, sync_d;
   logic [6:0]                  sample;
   logic [6:0]                  prev_q, prev_d;
   logic [6:0]                  last_q, last_d;
   logic [7:0]                  run_q, run_d;
   logic [3:0]                  char_code_q, char_code_d;
   logic                        char_valid_q, char_valid_d;
   logic                        char_unknown_q, char_unknown_d;
   logic [4:0]                  msg_pos_q, msg_pos_d;
   logic                        msg_done_q, msg_done_d;
   logic [COUNT_W-1:0]          msg_count_q, msg_count_d;
   logic                        accept;

   function automatic logic [3:0] decode(input logic [6:0] pat);
      case (pat)
         7'h00:   decode = 4'd0;
         7'h3E:   decode = 4'd1;
         7'h77:   decode = 4'd2;
         7'h7C:   decode = 4'd3;
         7'h39:   decode = 4'd4;
         7'h40:   decode = 4'd5;
         7'h79:   decode = 4'd6;
         7'h38:   decode = 4'd7;
         7'h31:   decode = 4'd8;
         7'h50:   decode = 4'd9;
         7'h3F:   decode = 4'd10;
         7'h54:   decode = 4'd11;
         7'h30:   decode = 4'd12;
         default: decode = 4'd15;
      endcase
   endfunction

   // Expected code at each banner position: U A B C - E L E C T R O N I C A
   function automatic logic [3:0] expected(input logic [3:0] pos);
      case (pos)
         4'd0:    expected = 4'd1;
         4'd1:    expected = 4'd2;
         4'd2:    expected = 4'd3;
         4'd3:    expected = 4'd4;
         4'd4:    expected = 4'd5;
         4'd5:    expected = 4'd6;
         4'd6:    expected = 4'd7;
         4'd7:    expected = 4'd6;
         4'd8:    expected = 4'd4;
         4'd9:    expected = 4'd8;
         4'd10:   expected = 4'd9;
         4'd11:   expected = 4'd10;
         4'd12:   expected = 4'd11;
         4'd13:   expected = 4'd12;
         4'd14:   expected = 4'd4;
         default: expected = 4'd2;
      endcase
   endfunction

`ifdef SEG7_ACTIVE_LOW_EN
   assign sample = ~sync_q[SYNC_STAGES-1];
`else
   assign sample = sync_q[SYNC_STAGES-1];
`endif

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], segments};
      prev_d = sample;
      if (sample == prev_q) begin
         run_d = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
      end else begin
         run_d = 8'd1;
      end
      // Acceptance is decided on the next run value so char_valid lands right after the qualifying edge
      accept         = (run_d == STABLE_N) && (sample != last_q);
      last_d         = accept ? sample : last_q;
      char_code_d    = accept ? decode(sample) : char_code_q;
      char_valid_d   = accept;
      char_unknown_d = accept && (decode(sample) == 4'd15);
   end

   always_comb begin
      msg_pos_d   = msg_pos_q;
      msg_done_d  = 1'b0;
      msg_count_d = msg_count_q;
      if (char_valid_q && (char_code_q != 4'd0)) begin
         if (char_code_q == expected(msg_pos_q[3:0])) begin
            if (msg_pos_q == 5'd15) begin
               msg_pos_d  = 5'd0;
               msg_done_d = 1'b1;
               if (msg_count_q != {COUNT_W{1'b1}}) begin
                  msg_count_d = msg_count_q + 1'b1;
               end
            end else begin
               msg_pos_d = msg_pos_q + 5'd1;
            end
         end else if (char_code_q == 4'd1) begin
            // A stray U is itself the start of a fresh banner
            msg_pos_d = 5'd1;
         end else begin
            msg_pos_d = 5'd0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q         <= {SYNC_STAGES{SYNC_RST}};
         prev_q         <= 7'h00;
         last_q         <= 7'h00;
         run_q          <= 8'd0;
         char_code_q    <= 4'd0;
         char_valid_q   <= 1'b0;
         char_unknown_q <= 1'b0;
         msg_pos_q      <= 5'd0;
         msg_done_q     <= 1'b0;
         msg_count_q    <= '0;
      end else begin
         sync_q         <= sync_d;
         prev_q         <= prev_d;
         last_q         <= last_d;
         run_q          <= run_d;
         char_code_q    <= char_code_d;
         char_valid_q   <= char_valid_d;
         char_unknown_q <= char_unknown_d;
         msg_pos_q      <= msg_pos_d;
         msg_done_q     <= msg_done_d;
         msg_count_q    <= msg_count_d;
      end
   end

   assign char_code    = char_code_q;
   assign char_valid   = char_valid_q;
   assign char_unknown = char_unknown_q;
   assign msg_pos      = msg_pos_q;
   assign msg_done     = msg_done_q;
   assign msg_count    = msg_count_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Scoreboard bench for seg7_reader: a default instance and a fast one (STABLE_CYCLES=1,
// SYNC_STAGES=3, COUNT_W=2) share one stimulus stream; a glyph-level model predicts both.
module tb_seg7_reader;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] segments = 7'h00;

   logic [3:0] a_code, b_code;
   logic       a_valid, b_valid, a_unk, b_unk, a_done, b_done;
   logic [4:0] a_pos, b_pos;
   logic [7:0] a_count;
   logic [1:0] b_count;

   seg7_reader dut_a (
      .clk(clk), .rst(rst), .segments(segments),
      .char_code(a_code), .char_valid(a_valid), .char_unknown(a_unk),
      .msg_pos(a_pos), .msg_done(a_done), .msg_count(a_count)
   );

   seg7_reader #(.STABLE_CYCLES(1), .SYNC_STAGES(3), .COUNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .segments(segments),
      .char_code(b_code), .char_valid(b_valid), .char_unknown(b_unk),
      .msg_pos(b_pos), .msg_done(b_done), .msg_count(b_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int code;
      int unk;
      int pos;
      int done;
      int cnt;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   int   checks = 0;
   int   errors = 0;

   // Glyph table indexed by code, and the banner as a list of codes
   logic [6:0] pats [13] = '{7'h00, 7'h3E, 7'h77, 7'h7C, 7'h39, 7'h40, 7'h79,
                             7'h38, 7'h31, 7'h50, 7'h3F, 7'h54, 7'h30};
   int msg_codes [16] = '{1, 2, 3, 4, 5, 6, 7, 6, 4, 8, 9, 10, 11, 12, 4, 2};

   int   m_runpat [2];
   int   m_runlen [2];
   int   m_last [2];
   int   m_pos [2];
   int   m_cnt [2];
   bit   pend [2];
   exp_t pexp [2];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int ref_code(input int pat);
      for (int i = 0; i < 13; i++) begin
         if (int'(pats[i]) == pat) return i;
      end
      return 15;
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         m_runpat[k] = 0;
         m_runlen[k] = 0;
         m_last[k]   = 0;
         m_pos[k]    = 0;
         m_cnt[k]    = 0;
      end
      qa.delete();
      qb.delete();
   endfunction

   // One sampling edge of input pattern pat as seen by instance k
   function automatic void model_step(input int k, input int pat);
      int   stab;
      int   cmax;
      exp_t e;
      stab = (k == 0) ? 4 : 1;
      cmax = (k == 0) ? 255 : 3;
      if (pat == m_runpat[k]) begin
         m_runlen[k]++;
      end else begin
         m_runpat[k] = pat;
         m_runlen[k] = 1;
      end
      if (m_runlen[k] == stab && pat != m_last[k]) begin
         m_last[k] = pat;
         e.code = ref_code(pat);
         e.unk  = (e.code == 15) ? 1 : 0;
         e.done = 0;
         if (e.code != 0) begin
            if (e.code == msg_codes[m_pos[k]]) begin
               if (m_pos[k] == 15) begin
                  m_pos[k] = 0;
                  e.done   = 1;
                  if (m_cnt[k] < cmax) m_cnt[k]++;
               end else begin
                  m_pos[k]++;
               end
            end else if (e.code == 15) begin
               m_pos[k] = 0;
            end else begin
               m_pos[k] = (e.code == 1) ? 1 : 0;
            end
         end
         e.pos = m_pos[k];
         e.cnt = m_cnt[k];
         if (k == 0) qa.push_back(e);
         else qb.push_back(e);
      end
   endfunction

   function automatic void step_all(input int pat);
      model_step(0, pat);
      model_step(1, pat);
   endfunction

   task automatic mon(input int k, input logic [3:0] code, input logic valid, input logic unk,
                      input logic [4:0] pos, input logic done, input int cnt);
      exp_t  e;
      string n;
      bit    empty;
      n = (k == 0) ? "a" : "b";
      if (pend[k]) begin
         chk({n, "_msg_pos"}, int'(pos), pexp[k].pos);
         chk({n, "_msg_done"}, int'(done), pexp[k].done);
         chk({n, "_msg_count"}, cnt, pexp[k].cnt);
         pend[k] = 1'b0;
      end else if (done) begin
         checks++;
         errors++;
         $display("FAIL %s_spurious_done: got 1 expected 0", n);
      end
      if (valid) begin
         empty = (k == 0) ? (qa.size() == 0) : (qb.size() == 0);
         if (empty) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected_valid: got code %0d expected no pulse", n, code);
         end else begin
            if (k == 0) e = qa.pop_front();
            else e = qb.pop_front();
            chk({n, "_char_code"}, int'(code), e.code);
            chk({n, "_char_unknown"}, int'(unk), e.unk);
            $display("%s glyph code=%0d unknown=%0d", n, code, unk);
            pexp[k] = e;
            pend[k] = 1'b1;
         end
      end else if (unk) begin
         checks++;
         errors++;
         $display("FAIL %s_spurious_unknown: got 1 expected 0", n);
      end
   endtask

   initial begin
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pend[0] = 1'b0;
            pend[1] = 1'b0;
         end else begin
            mon(0, a_code, a_valid, a_unk, a_pos, a_done, int'(a_count));
            mon(1, b_code, b_valid, b_unk, b_pos, b_done, int'(b_count));
         end
      end
   end

   task automatic hold(input logic [6:0] pat, input int n);
      repeat (n) begin
         @(negedge clk);
         segments = pat;
         @(posedge clk);
         step_all(int'(pat));
      end
   endtask

   // Reset asserted between edges; outputs must clear without waiting for a clock
   task automatic do_reset(input logic [6:0] pat);
      @(posedge clk);
      #2;
      segments = pat;
      rst = 1'b1;
      #1;
      chk("a_reset_outputs", int'({a_code, a_valid, a_unk, a_pos, a_done, a_count}), 0);
      chk("b_reset_outputs", int'({b_code, b_valid, b_unk, b_pos, b_done, b_count}), 0);
      model_reset();
      repeat (3) @(negedge clk);
      chk("a_reset_held", int'({a_code, a_valid, a_unk, a_pos, a_done, a_count}), 0);
      rst = 1'b0;
   endtask

   initial begin
      int lat_a;
      int lat_b;
      logic [6:0] p;
      model_reset();

      // Steady U across reset: exactly one acceptance after the full latency
      do_reset(7'h3E);
      lat_a = 0;
      lat_b = 0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk);
         step_all(7'h3E);
         @(negedge clk);
         if (a_valid && lat_a == 0) lat_a = i;
         if (b_valid && lat_b == 0) lat_b = i;
      end
      chk("a_latency_edges", lat_a, 6);
      chk("b_latency_edges", lat_b, 4);
      hold(7'h3E, 50);

      // Short A glitch then back to U
      hold(7'h77, 3);
      hold(7'h3E, 20);
      chk("a_glitch_pos", int'(a_pos), 1);

      // U A C, then U blank U
      hold(7'h3E, 10); hold(7'h77, 10); hold(7'h39, 10);
      hold(7'h3E, 10); hold(7'h00, 10); hold(7'h3E, 10);

      // All segments lit: unknown glyph
      hold(7'h7F, 10);

      // Banner five times, separated by blanks
      hold(7'h00, 10);
      for (int r = 0; r < 5; r++) begin
         for (int j = 0; j < 16; j++) begin
            p = pats[msg_codes[j]];
            hold(p, 10);
         end
         hold(7'h00, 10);
      end
      chk("a_count_after_5", int'(a_count), 5);
      chk("b_count_saturated", int'(b_count), 3);

      // Mid-operation reset with counters non-zero
      do_reset(7'h00);

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) < 8) p = pats[$urandom_range(0, 12)];
         else p = 7'($urandom_range(0, 127));
         hold(p, $urandom_range(1, 7));
      end
      // A banner inside the random stream as well
      for (int j = 0; j < 16; j++) begin
         p = pats[msg_codes[j]];
         hold(p, $urandom_range(4, 6));
      end
      hold(7'h00, 20);
      chk("a_queue_drained", qa.size(), 0);
      chk("b_queue_drained", qb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
